// File: rtl/demux_rr_scheduler_if.sv
// Handshake/bus bundle for the round-robin demux scheduler: control and serial
// data from the source side, channel select and demux outputs toward consumers.
interface demux_rr_scheduler_if #(
  parameter int DW = 4
) ();
  logic          start;
  logic          stop;
  logic [7:0]    en_mask;
  logic [DW-1:0] dwell;
  logic          d_in;
  logic [2:0]    sel;
  logic [7:0]    y;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, stop, en_mask, dwell, d_in,
    input  sel, y, busy, frame_done
  );

  modport slave (
    input  start, stop, en_mask, dwell, d_in,
    output sel, y, busy, frame_done
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Time-division sequencer: walks sel round-robin over a latched channel mask,
// holding each channel for a programmable dwell, and routes d_in through a registered 1:8 demux.
module demux_rr_scheduler #(
  parameter int DW = 4
) (
  input logic                  clk,
  input logic                  rst,
  demux_rr_scheduler_if.slave  bus
);

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    RUN      = 1'b1;
  localparam logic [DW-1:0] DW_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0] DW_ONE   = {{(DW-1){1'b0}}, 1'b1};

  // Lowest set bit of the mask (mask is known non-zero where this is used).
  function automatic logic [2:0] lowest_enabled(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // First enabled index after cur, searching cur+1 .. cur+7 modulo 8; cur itself if none.
  function automatic logic [2:0] next_enabled(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] nxt;
    logic [2:0] idx;
    nxt = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) begin
        nxt = idx;
      end
    end
    return nxt;
  endfunction

  logic [0:0]    state_r,  state_n_s;
  logic [2:0]    sel_r,    sel_n_s;
  logic [7:0]    y_r,      y_n_s;
  logic          busy_r,   busy_n_s;
  logic          fd_r,     fd_n_s;
  logic [7:0]    mask_r,   mask_n_s;
  logic [DW-1:0] dwell_r,  dwell_n_s;
  logic [DW-1:0] cnt_r,    cnt_n_s;
  logic          stop_r,   stop_n_s;
  logic [DW-1:0] dwell_eff_s;
  logic [2:0]    next_sel_s;
  logic          stop_any_s;

  // Next-state and next-output computation for the scan FSM.
  always_comb begin
    state_n_s   = state_r;
    sel_n_s     = sel_r;
    y_n_s       = 8'h00;
    busy_n_s    = busy_r;
    fd_n_s      = 1'b0;
    mask_n_s    = mask_r;
    dwell_n_s   = dwell_r;
    cnt_n_s     = cnt_r;
    stop_n_s    = stop_r;
    dwell_eff_s = (bus.dwell == DW_ZERO) ? DW_ONE : bus.dwell;
    next_sel_s  = next_enabled(mask_r, sel_r);
    stop_any_s  = stop_r | bus.stop;

    case (state_r)
      IDLE: begin
        if (bus.start && (bus.en_mask != 8'h00)) begin
          mask_n_s  = bus.en_mask;
          dwell_n_s = dwell_eff_s;
          sel_n_s   = lowest_enabled(bus.en_mask);
          cnt_n_s   = dwell_eff_s - DW_ONE;
          stop_n_s  = 1'b0;
          state_n_s = RUN;
          busy_n_s  = 1'b1;
        end else begin
          busy_n_s  = 1'b0;
        end
      end
      RUN: begin
        y_n_s[sel_r] = bus.d_in;
        if (cnt_r == DW_ZERO) begin
          // A wrap (next <= current, incl. single channel) closes the round.
          fd_n_s   = (next_sel_s <= sel_r);
          stop_n_s = 1'b0;
          if (stop_any_s) begin
            state_n_s = IDLE;
            busy_n_s  = 1'b0;
          end else begin
            sel_n_s = next_sel_s;
            cnt_n_s = dwell_r - DW_ONE;
          end
        end else begin
          cnt_n_s  = cnt_r - DW_ONE;
          stop_n_s = stop_any_s;
        end
      end
      default: begin
        state_n_s = IDLE;
        busy_n_s  = 1'b0;
        stop_n_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= 3'd0;
      y_r     <= 8'h00;
      busy_r  <= 1'b0;
      fd_r    <= 1'b0;
      mask_r  <= 8'h00;
      dwell_r <= DW_ZERO;
      cnt_r   <= DW_ZERO;
      stop_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      sel_r   <= sel_n_s;
      y_r     <= y_n_s;
      busy_r  <= busy_n_s;
      fd_r    <= fd_n_s;
      mask_r  <= mask_n_s;
      dwell_r <= dwell_n_s;
      cnt_r   <= cnt_n_s;
      stop_r  <= stop_n_s;
    end
  end

  assign bus.sel        = sel_r;
  assign bus.y          = y_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Randomized self-checking bench for demux_rr_scheduler against a slot-level behavioural model.
module tb_demux_rr_scheduler;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  demux_rr_scheduler_if #(.DW(4)) bus ();

  demux_rr_scheduler #(.DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: running flag, mask, slot length, cycles elapsed in the slot, pending stop.
  logic       chk_en;
  logic       m_run;
  logic [7:0] m_mask;
  int         m_dwell;
  int         m_elapsed;
  logic       m_stop;
  logic [2:0] exp_sel;
  logic [7:0] exp_y;
  logic       exp_busy;
  logic       exp_fd;

  initial chk_en = 1'b0;

  always @(posedge clk) begin
    int en_q[$];
    int nxt;
    logic wrapped;
    if (rst) begin
      chk_en    = 1'b1;
      m_run     = 1'b0;
      m_mask    = 8'h00;
      m_dwell   = 0;
      m_elapsed = 0;
      m_stop    = 1'b0;
      exp_sel   = 3'd0;
      exp_y     = 8'h00;
      exp_busy  = 1'b0;
      exp_fd    = 1'b0;
    end else begin
      exp_fd = 1'b0;
      exp_y  = 8'h00;
      if (!m_run) begin
        if (bus.start && bus.en_mask != 8'h00) begin
          m_mask  = bus.en_mask;
          m_dwell = (bus.dwell == 4'd0) ? 1 : int'(bus.dwell);
          en_q.delete();
          for (int k = 0; k < 8; k++) if (m_mask[k]) en_q.push_back(k);
          exp_sel   = 3'(en_q[0]);
          m_elapsed = 0;
          m_stop    = 1'b0;
          m_run     = 1'b1;
        end
      end else begin
        exp_y[exp_sel] = bus.d_in;
        if (bus.stop) m_stop = 1'b1;
        m_elapsed++;
        if (m_elapsed == m_dwell) begin
          en_q.delete();
          for (int k = 0; k < 8; k++) if (m_mask[k]) en_q.push_back(k);
          nxt = -1;
          foreach (en_q[j]) if (nxt < 0 && en_q[j] > int'(exp_sel)) nxt = en_q[j];
          wrapped = (nxt < 0);
          if (wrapped) nxt = en_q[0];
          exp_fd = wrapped;
          if (m_stop) m_run = 1'b0;
          else exp_sel = 3'(nxt);
          m_elapsed = 0;
          m_stop    = 1'b0;
        end
      end
      exp_busy = m_run;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", 8'(bus.sel), 8'(exp_sel));
      check("y", bus.y, exp_y);
      check("busy", 8'(bus.busy), 8'(exp_busy));
      check("frame_done", 8'(bus.frame_done), 8'(exp_fd));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] m, input logic [3:0] d);
    bus.en_mask = m;
    bus.dwell   = d;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic stop_and_wait();
    int n;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check("stop_timeout_busy", 8'(bus.busy), 8'h00);
    tick();
  endtask

  initial begin
    int fd_cnt;
    logic [7:0] yor;
    logic [2:0] seq [6];
    logic [2:0] exp_seq [6];
    logic din_v;

    n_pass = 0; n_total = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.en_mask = 8'h00; bus.dwell = 4'd0; bus.d_in = 1'b1;
    tick(); tick();
    check("rst_sel", 8'(bus.sel), 8'h00);
    check("rst_y", bus.y, 8'h00);
    check("rst_busy", 8'(bus.busy), 8'h00);
    check("rst_fd", 8'(bus.frame_done), 8'h00);
    rst = 1'b0;

    launch(8'h00, 4'd2);
    tick();
    check("empty_mask_busy", 8'(bus.busy), 8'h00);

    // Full scan, dwell 2: sel 7 -> 0 with frame_done on the 16th edge.
    bus.d_in = 1'b1;
    launch(8'hFF, 4'd2);
    check("scan_start_sel", 8'(bus.sel), 8'h00);
    fd_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.frame_done) fd_cnt++;
      if (c == 14) check("scan_sel7", 8'(bus.sel), 8'h07);
      if (c == 16) begin
        check("scan_wrap_sel", 8'(bus.sel), 8'h00);
        check("scan_wrap_fd", 8'(bus.frame_done), 8'h01);
      end
    end
    check("scan_fd_count", 8'(fd_cnt), 8'h01);
    stop_and_wait();

    // Sparse mask with wrap, dwell 1.
    exp_seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};
    launch(8'hA4, 4'd1);
    seq[0] = bus.sel;
    fd_cnt = 0; yor = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c < 6) seq[c] = bus.sel;
      if (bus.frame_done) fd_cnt++;
      yor = yor | bus.y;
    end
    for (int c = 0; c < 6; c++) check("sparse_seq", 8'(seq[c]), 8'(exp_seq[c]));
    check("sparse_fd_count", 8'(fd_cnt), 8'h02);
    check("sparse_y_disabled", yor & 8'h5B, 8'h00);
    stop_and_wait();

    // Single channel, dwell 0 behaves as a 1-cycle slot.
    launch(8'h08, 4'd0);
    for (int c = 0; c < 8; c++) begin
      din_v = 1'($urandom);
      bus.d_in = din_v;
      tick();
      check("single_sel", 8'(bus.sel), 8'h03);
      check("single_fd", 8'(bus.frame_done), 8'h01);
      check("single_y", bus.y, {4'b0000, din_v, 3'b000});
    end
    stop_and_wait();

    // Stop pulsed in cycle 2 of a 4-cycle slot on channel 1.
    bus.d_in = 1'b1;
    launch(8'h06, 4'd4);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    check("stop_busy_mid", 8'(bus.busy), 8'h01);
    tick();
    check("stop_busy_end", 8'(bus.busy), 8'h00);
    check("stop_sel", 8'(bus.sel), 8'h01);
    check("stop_y_last", bus.y, 8'h02);
    tick();
    check("stop_y_clear", bus.y, 8'h00);
    launch(8'h30, 4'd1);
    check("restart_sel", 8'(bus.sel), 8'h04);
    stop_and_wait();

    // Reset during a slot on channel 5.
    launch(8'h24, 4'd3);
    repeat (4) tick();
    check("pre_rst_sel", 8'(bus.sel), 8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sel", 8'(bus.sel), 8'h00);
    check("midrst_busy", 8'(bus.busy), 8'h00);
    check("midrst_fd", 8'(bus.frame_done), 8'h00);
    launch(8'h24, 4'd3);
    check("post_rst_sel", 8'(bus.sel), 8'h02);
    stop_and_wait();

    // Randomized phase: arbitrary masks, dwells, start/stop/rst traffic.
    for (int it = 0; it < 25; it++) begin
      bus.en_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus.dwell   = 4'($urandom_range(0, 15));
      bus.start   = 1'b1;
      for (int c = 0; c < 40; c++) begin
        tick();
        bus.start = ($urandom_range(0, 9) == 0);
        bus.stop  = ($urandom_range(0, 19) == 0);
        bus.d_in  = 1'($urandom);
        rst       = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 7) == 0) bus.en_mask = 8'($urandom);
        if ($urandom_range(0, 7) == 0) bus.dwell = 4'($urandom_range(0, 15));
      end
      bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
      stop_and_wait();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
